// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM command-port arbiter.
// Used by the arbiter FSM and its refresh scheduler.
package sdram_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GNT_RD  = 3'd1;
  localparam logic [2:0] ST_WAIT_RD = 3'd2;
  localparam logic [2:0] ST_GNT_WR  = 3'd3;
  localparam logic [2:0] ST_REFRESH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_GNT_RD  = ST_GNT_RD,
    S_WAIT_RD = ST_WAIT_RD,
    S_GNT_WR  = ST_GNT_WR,
    S_REFRESH = ST_REFRESH
  } state_t;

endpackage

// File: rtl/sdram_refresh_sched.sv
// Refresh interval timer and saturating count of owed refreshes.
// force_ref flags that the refresh backlog may no longer be deferred.
module sdram_refresh_sched
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REFI_CYCLES = 1040,
  parameter int unsigned MAX_PEND    = 8,
  parameter int unsigned FORCE_PEND  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ref_ack,
  output logic [3:0] pend,
  output logic       force_ref
);

  localparam int CW = $clog2(REFI_CYCLES);

  logic [CW-1:0] cnt;
  logic          wrap;
  logic          inc;
  logic          dec;

  assign wrap = (cnt == CW'(REFI_CYCLES - 1));
  assign inc  = wrap && (pend != 4'(MAX_PEND));
  assign dec  = ref_ack && (pend != 4'd0);

  assign force_ref = (pend >= 4'(FORCE_PEND));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      pend <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      // a wrap and an ack together cancel out
      if (wrap && dec) begin
        pend <= pend;
      end else if (inc) begin
        pend <= pend + 4'd1;
      end else if (dec) begin
        pend <= pend - 4'd1;
      end
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates QSPI reads, USB writes and auto-refresh onto one
// SDRAM command port; reads have priority, writes are anti-starved.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REFI_CYCLES   = 1040,
  parameter int unsigned MAX_PEND      = 8,
  parameter int unsigned FORCE_PEND    = 6,
  parameter int unsigned MAX_RD_STREAK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_avalid,
  output logic              rd_aready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              forbid_refresh,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  output logic              ref_req,
  input  logic              ref_ack,
  output logic [3:0]        pend_cnt
);

  localparam int SW = $clog2(MAX_RD_STREAK + 1);

  state_t        state;
  logic [SW-1:0] streak;
  logic [3:0]    pend;
  logic          force_ref;
  logic          go_ref;
  logic          wr_first;

  sdram_refresh_sched #(
    .REFI_CYCLES(REFI_CYCLES),
    .MAX_PEND   (MAX_PEND),
    .FORCE_PEND (FORCE_PEND)
  ) u_sched (
    .clk      (clk),
    .rst      (rst),
    .ref_ack  (ref_ack),
    .pend     (pend),
    .force_ref(force_ref)
  );

  assign pend_cnt = pend;
  assign go_ref   = force_ref || ((pend != 4'd0) && !forbid_refresh);
  assign wr_first = wr_valid && (streak >= SW'(MAX_RD_STREAK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      streak <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go_ref) begin
            state <= S_REFRESH;
          end else if (wr_first) begin
            state <= S_GNT_WR;
          end else if (rd_avalid) begin
            state <= S_GNT_RD;
          end else if (wr_valid) begin
            state <= S_GNT_WR;
          end
        end
        S_GNT_RD: begin
          if (rd_avalid && mem_ready) begin
            state <= S_WAIT_RD;
            if (streak != SW'(MAX_RD_STREAK)) begin
              streak <= streak + 1'b1;
            end
          end
        end
        S_WAIT_RD: begin
          if (mem_rvalid && rd_ready) begin
            state <= S_IDLE;
          end
        end
        S_GNT_WR: begin
          if (wr_valid && mem_ready) begin
            state  <= S_IDLE;
            streak <= '0;
          end
        end
        S_REFRESH: begin
          if (ref_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // grant-state pass-throughs; idle states drive all zeros
  always_comb begin
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rd_aready  = 1'b0;
    wr_ready   = 1'b0;
    rd_data    = '0;
    rd_valid   = 1'b0;
    mem_rready = 1'b0;
    ref_req    = 1'b0;
    unique case (state)
      S_GNT_RD: begin
        mem_valid = rd_avalid;
        mem_addr  = rd_addr;
        rd_aready = mem_ready;
      end
      S_WAIT_RD: begin
        rd_data    = mem_rdata;
        rd_valid   = mem_rvalid;
        mem_rready = rd_ready;
      end
      S_GNT_WR: begin
        mem_valid = wr_valid;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        wr_ready  = mem_ready;
      end
      S_REFRESH: ref_req = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: directed traffic,
// refresh deferral, counter corner cases and mid-read reset.
module tb_sdram_req_arbiter;

  localparam int REFI = 1040;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rd_addr;
  logic        rd_avalid;
  logic        rd_aready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        forbid_refresh;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rready;
  logic        ref_req;
  logic        ref_ack;
  logic [3:0]  pend_cnt;

  logic ack_auto;
  logic ack_man;
  logic auto_ack;
  logic hold_resp;
  int   rd_lat;

  cmd_t        cmd_q[$];
  logic [15:0] rd_q[$];
  cmd_t        e_cmd;
  logic [15:0] e_rd;
  int          n_vec = 0;
  int          n_err = 0;

  assign ref_ack = ack_auto | ack_man;

  always #5 clk = ~clk;

  sdram_req_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .rd_addr       (rd_addr),
    .rd_avalid     (rd_avalid),
    .rd_aready     (rd_aready),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .forbid_refresh(forbid_refresh),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rready    (mem_rready),
    .ref_req       (ref_req),
    .ref_ack       (ref_ack),
    .pend_cnt      (pend_cnt)
  );

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] outs_a();
    return 96'({mem_valid, mem_we, mem_addr, mem_wdata});
  endfunction

  function automatic logic [95:0] outs_b();
    return 96'({rd_aready, rd_valid, rd_data, wr_ready,
                mem_rready, ref_req, pend_cnt});
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid && mem_ready) begin
        if (cmd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL cmd_unexpected: got we=%0b addr=%0h",
                   mem_we, mem_addr);
        end else begin
          e_cmd = cmd_q.pop_front();
          chk("cmd", 96'({mem_we, mem_addr, mem_we ? mem_wdata : 16'h0}),
              96'(e_cmd));
        end
      end
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected: got %0h", rd_data);
        end else begin
          e_rd = rd_q.pop_front();
          chk("rd_data", 96'(rd_data), 96'(e_rd));
        end
      end
    end
  end

  // memory read responder: rdata = addr[15:0] ^ A4A5
  initial begin : responder
    logic        hs_cmd;
    logic        hs_dat;
    logic [23:0] ad;
    logic [23:0] r_addr;
    int          cnt;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    cnt        = -1;
    r_addr     = '0;
    forever begin
      @(negedge clk);
      hs_cmd = mem_valid && mem_ready && !mem_we;
      hs_dat = mem_rvalid && mem_rready;
      ad     = mem_addr;
      @(posedge clk);
      #1;
      if (rst) begin
        mem_rvalid = 1'b0;
        cnt        = -1;
      end else begin
        if (hs_dat) mem_rvalid = 1'b0;
        if (hs_cmd) begin
          cnt    = rd_lat;
          r_addr = ad;
        end else if (cnt > 0) begin
          cnt--;
        end
        if (cnt == 0 && !hold_resp) begin
          mem_rvalid = 1'b1;
          mem_rdata  = r_addr[15:0] ^ 16'hA4A5;
          cnt        = -1;
        end
      end
    end
  end

  initial begin : ref_responder
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && ref_req && !rst) begin
        @(posedge clk);
        #1 ack_auto = 1'b1;
        @(posedge clk);
        #1 ack_auto = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    rd_avalid = 1'b0;
    wr_valid  = 1'b0;
    ack_man   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_pend(input logic [3:0] v, input int lim,
                           input string nm);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (pend_cnt == v) break;
    end
    chk(nm, 96'(pend_cnt), 96'(v));
  endtask

  task automatic wait_cmd(input string nm);
    int k;
    k = 0;
    while (!(mem_valid && mem_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 96'(mem_valid && mem_ready), 96'(1));
  endtask

  task automatic wait_rdat(input string nm);
    int k;
    k = 0;
    while (!(rd_valid && rd_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 96'(rd_valid && rd_ready), 96'(1));
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    rd_addr        = '0;
    rd_avalid      = 1'b0;
    rd_ready       = 1'b1;
    wr_addr        = '0;
    wr_data        = '0;
    wr_valid       = 1'b0;
    forbid_refresh = 1'b0;
    mem_ready      = 1'b1;
    ack_man        = 1'b0;
    auto_ack       = 1'b1;
    hold_resp      = 1'b0;
    rd_lat         = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_a", outs_a(), 96'(0));
    chk("reset_outs_b", outs_b(), 96'(0));
    rst = 1'b0;

    // single read, grant latency, return to idle
    @(posedge clk);
    #1;
    rd_addr   = 24'h000100;
    rd_avalid = 1'b1;
    cmd_q.push_back({1'b0, 24'h000100, 16'h0000});
    rd_q.push_back(16'hA5A5);
    @(negedge clk);
    chk("t1_idle_cycle", 96'(mem_valid), 96'(0));
    @(negedge clk);
    chk("t1_grant", 96'({mem_valid, mem_we, mem_addr, rd_aready}),
        96'({1'b1, 1'b0, 24'h000100, 1'b1}));
    @(posedge clk);
    #1 rd_avalid = 1'b0;
    wait_rdat("t1_rd_done");
    @(negedge clk);
    chk("t1_idle_after", 96'({mem_valid, rd_valid, rd_aready, mem_rready}),
        96'(0));

    // read/write contention: 16 reads, 1 write, reads resume
    do_reset();
    @(posedge clk);
    #1;
    rd_addr   = 24'h000300;
    wr_addr   = 24'h00ABCD;
    wr_data   = 16'h1234;
    rd_avalid = 1'b1;
    wr_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cmd_q.push_back({1'b0, 24'h000300, 16'h0000});
      rd_q.push_back(16'hA7A5);
    end
    cmd_q.push_back({1'b1, 24'h00ABCD, 16'h1234});
    for (int i = 0; i < 2; i++) begin
      cmd_q.push_back({1'b0, 24'h000300, 16'h0000});
      rd_q.push_back(16'hA7A5);
    end
    n = 0;
    for (int c = 0; c < 400 && n < 19; c++) begin
      @(negedge clk);
      if (mem_valid && mem_ready) n++;
    end
    chk("t2_grant_count", 96'(n), 96'(19));
    @(posedge clk);
    #1;
    rd_avalid = 1'b0;
    wr_valid  = 1'b0;
    repeat (10) @(negedge clk);

    // forbid_refresh defers until backlog reaches force level
    do_reset();
    auto_ack       = 1'b0;
    forbid_refresh = 1'b1;
    wait_pend(4'd1, REFI + 20, "t3_pend1");
    repeat (5) @(negedge clk);
    chk("t3_deferred", 96'(ref_req), 96'(0));
    wait_pend(4'd6, 5 * REFI + 50, "t3_pend6");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ref_req) break;
    end
    chk("t3_forced", 96'(ref_req), 96'(1));
    @(posedge clk);
    #1 ack_man = 1'b1;
    @(posedge clk);
    #1 ack_man = 1'b0;
    @(negedge clk);
    chk("t3_pend_after_ack", 96'(pend_cnt), 96'(5));
    chk("t3_refreq_drop", 96'(ref_req), 96'(0));

    // wrap and ack on the same edge leave pend unchanged
    do_reset();
    wait_pend(4'd1, REFI + 20, "t4_pend1");
    wait_pend(4'd2, REFI + 20, "t4_pend2");
    repeat (REFI - 1) @(posedge clk);
    #1 ack_man = 1'b1;
    @(posedge clk);
    #1 ack_man = 1'b0;
    @(negedge clk);
    chk("t4_wrap_ack", 96'(pend_cnt), 96'(2));
    wait_pend(4'd3, REFI + 20, "t4_next_wrap");

    // no acks: backlog saturates at 8
    do_reset();
    forbid_refresh = 1'b0;
    repeat (8 * REFI + 5) @(posedge clk);
    @(negedge clk);
    chk("t5_pend8", 96'(pend_cnt), 96'(8));
    repeat (2 * REFI) @(posedge clk);
    @(negedge clk);
    chk("t5_saturated", 96'({ref_req, pend_cnt}), 96'({1'b1, 4'd8}));

    // reset while a read is outstanding
    do_reset();
    auto_ack  = 1'b1;
    hold_resp = 1'b1;
    @(posedge clk);
    #1;
    rd_addr   = 24'h000400;
    rd_avalid = 1'b1;
    cmd_q.push_back({1'b0, 24'h000400, 16'h0000});
    wait_cmd("t6_cmd");
    @(posedge clk);
    #1 rd_avalid = 1'b0;
    @(negedge clk);
    chk("t6_in_wait_rd", 96'(mem_rready), 96'(1));
    #2 rst = 1'b1;
    #1;
    chk("t6_reset_outs_a", outs_a(), 96'(0));
    chk("t6_reset_outs_b", outs_b(), 96'(0));
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    hold_resp = 1'b0;
    rd_lat    = 3;
    @(posedge clk);
    #1;
    rd_addr   = 24'h000200;
    rd_avalid = 1'b1;
    cmd_q.push_back({1'b0, 24'h000200, 16'h0000});
    rd_q.push_back(16'hA6A5);
    wait_cmd("t6_cmd2");
    @(posedge clk);
    #1 rd_avalid = 1'b0;
    wait_rdat("t6_rd2_done");
    repeat (5) @(negedge clk);
    chk("queues_drained", 96'(cmd_q.size() + rd_q.size()), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
Shares the single SDRAM controller command port between two requesters. The QSPI read path is latency-critical and gets priority. The USB write path is starvation-protected. The block also schedules auto-refresh and honours the QSPI-side forbid-refresh hint, with a bounded deferral. It sits between qspi2sdram_top / cyp2sdram_top and sdram_top in the sd_clk domain.

Parameters:
REFI_CYCLES, 1040, sd_clk cycles per refresh interval (7.8 us at 133 MHz)
MAX_PEND, 8, saturation limit of the owed-refresh counter
FORCE_PEND, 6, pending count at which refresh overrides forbid_refresh
MAX_RD_STREAK, 16, consecutive read grants after which a waiting write wins

Ports:
clk  in  1  sd_clk, 133 MHz
rst  in  1  asynchronous, active-high reset
rd_addr  in  24  QSPI read word address
rd_avalid  in  1  read address valid
rd_aready  out  1  read address accepted
rd_data  out  16  read data to QSPI side
rd_valid  out  1  read data valid
rd_ready  in  1  QSPI side accepts read data
wr_addr  in  24  USB write word address
wr_data  in  16  USB write data
wr_valid  in  1  write valid
wr_ready  out  1  write accepted
forbid_refresh  in  1  QSPI burst in progress; defer refresh
mem_valid  out  1  command valid to sdram_top
mem_ready  in  1  sdram_top accepts command
mem_we  out  1  1 = write, 0 = read
mem_addr  out  24  command address
mem_wdata  out  16  write data
mem_rdata  in  16  read data from sdram_top
mem_rvalid  in  1  read data valid from sdram_top
mem_rready  out  1  back-pressure to sdram_top
ref_req  out  1  refresh request, level
ref_ack  in  1  one-cycle pulse when refresh is issued
pend_cnt  out  4  owed refreshes (debug)

Behaviour:
Reset values:
- rst asserted: all outputs 0, state IDLE, refi counter 0, pend 0, streak 0.
- rst asserted mid-transaction: all handshakes are dropped immediately; requesters must re-issue.

Refresh timer:
- Counter counts 0..REFI_CYCLES-1. On the wrap cycle, pend += 1, saturating at MAX_PEND.
- ref_ack decrements pend.
- Wrap and ref_ack in the same cycle: pend unchanged.
- ref_ack while pend is 0: ignored.

State machine states: IDLE, GNT_RD, WAIT_RD, GNT_WR, REFRESH.

IDLE decision, evaluated every cycle, first match wins:
1. pend ≥ FORCE_PEND -> REFRESH.
2. pend > 0 and !forbid_refresh -> REFRESH.
3. wr_valid and streak ≥ MAX_RD_STREAK -> GNT_WR.
4. rd_avalid -> GNT_RD.
5. wr_valid -> GNT_WR.

GNT_RD:
- mem_valid = rd_avalid, mem_we = 0, mem_addr = rd_addr, rd_aready = mem_ready. All are combinational pass-throughs.
- On the mem handshake: streak += 1 (saturating) and go to WAIT_RD.

WAIT_RD:
- rd_data = mem_rdata, rd_valid = mem_rvalid, mem_rready = rd_ready.
- On the rd_valid & rd_ready handshake -> IDLE.
- Only one read is outstanding at any time.

GNT_WR:
- mem_valid = wr_valid, mem_we = 1, mem_addr = wr_addr, mem_wdata = wr_data, wr_ready = mem_ready.
- On the handshake: streak = 0 and go to IDLE.

REFRESH:
- ref_req = 1 and mem_valid = 0.
- On ref_ack -> IDLE.

Timing and handshake rules:
- Grant latency: a request seen in IDLE at cycle N has mem_valid at cycle N+1.
- A requester that deasserts valid while granted is a protocol violation; the arbiter is not required to handle it.
- rd_aready and wr_ready are 0 in every state other than their own grant state.
- forbid_refresh never blocks a refresh once pend ≥ FORCE_PEND. This bounds deferral to FORCE_PEND × REFI_CYCLES.

Decomposition:
- Shared package sdram_arb_pkg: state encoding (3-bit localparams), address and data widths (24/16).
- Sub-module sdram_refresh_sched: refi counter plus saturating pend counter, with outputs pend and force.
- Top block: FSM plus the pass-through muxing.

Test Plan:
- Reset, then rd_avalid with rd_addr=24'h000100 and mem_ready=1 -> mem_valid at cycle 1 with mem_we=0 and mem_addr=24'h000100. Return mem_rdata=16'hA5A5 -> rd_data=16'hA5A5, then state is IDLE.
- rd_avalid and wr_valid held continuously -> exactly 16 read grants, then 1 write grant, then reads resume.
- pend=1 with forbid_refresh=1 -> no ref_req. Hold forbid until pend reaches 6 -> ref_req asserts with forbid still 1; ref_ack -> pend becomes 5.
- Refi wrap and ref_ack in the same cycle with pend=2 -> pend stays 2.
- No refresh acks for 10×REFI_CYCLES -> pend saturates at 8 and does not wrap.
- Assert rst during WAIT_RD -> all outputs 0 within the same cycle. After release, a new read completes normally.
